// File: rtl/prio_encoder_stream.sv
// prio_encoder_stream
//
// Streaming priority encoder. A WIDTH-bit request word is accepted over a
// valid/ready handshake, and bit indices come back over a second valid/ready
// handshake.
//   mode=0 (priority)  : one beat per word, holding the index of the priority bit.
//   mode=1 (enumerate) : one beat per set bit, in priority order; out_last marks
//                        the final beat of the word.
// An all-zero word always produces a single beat with out_zero=1, out_code=0 and
// out_last=1.
// MSB_FIRST selects which end has priority, and therefore also sets the
// enumeration order.
//
// Optional feature: when PRIO_ENCODER_COUNT_EN is defined, the out_count port is
// added. It carries popcount(in_data), registered on acceptance and held for
// every beat of that word.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_data    request word
//   in_valid   in_data valid
//   in_ready   block can accept a word
//   mode       0 = priority, 1 = enumerate (sampled on accept only)
//   out_code   bit index
//   out_zero   accepted word was all zero
//   out_last   final code for the current word
//   out_valid  output beat valid
//   out_ready  consumer takes the current beat
//   out_count  popcount of the accepted word (PRIO_ENCODER_COUNT_EN only)

module prio_encoder_stream #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CODE_W    = $clog2(WIDTH),
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    output logic [CODE_W-1:0] out_code,
    output logic              out_zero,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
`ifdef PRIO_ENCODER_COUNT_EN
    ,
    output logic [CODE_W:0]   out_count
`endif
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e              state_q;
    logic [WIDTH-1:0]    residual_q;
    logic [CODE_W-1:0]   code_q;
    logic                zero_q;
    logic                last_q;
    logic                valid_q;

    logic                accept;
    logic                consume;
    logic [CODE_W-1:0]   in_idx;
    logic [WIDTH-1:0]    in_rest;
    logic [CODE_W-1:0]   res_idx;
    logic [WIDTH-1:0]    res_rest;

    // Index of the priority bit. The scan runs so that the winning bit is
    // visited last and therefore overwrites every other candidate.
    function automatic logic [CODE_W-1:0] prio_idx(input logic [WIDTH-1:0] d);
        logic [CODE_W-1:0] idx;
        int unsigned       j;
        idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            j = MSB_FIRST ? i : (WIDTH - 1 - i);
            if (d[j]) begin
                idx = CODE_W'(j);
            end
        end
        return idx;
    endfunction

`ifdef PRIO_ENCODER_COUNT_EN
    logic [CODE_W:0] count_q;

    function automatic logic [CODE_W:0] popcount(input logic [WIDTH-1:0] d);
        logic [CODE_W:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt = cnt + (CODE_W + 1)'(d[i]);
        end
        return cnt;
    endfunction

    assign out_count = count_q;
`endif

    always_comb begin
        in_idx            = prio_idx(in_data);
        in_rest           = in_data;
        in_rest[in_idx]   = 1'b0;
        res_idx           = prio_idx(residual_q);
        res_rest          = residual_q;
        res_rest[res_idx] = 1'b0;
    end

    // rst_n is folded in so that in_ready is low for the whole time reset is asserted.
    assign in_ready = rst_n & (state_q == StIdle) & (~valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign consume  = valid_q & out_ready;

    assign out_code  = code_q;
    assign out_zero  = zero_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            residual_q <= '0;
            code_q     <= '0;
            zero_q     <= 1'b0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
`ifdef PRIO_ENCODER_COUNT_EN
            count_q    <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    // A simultaneous accept and consume replaces the beat with no bubble.
                    if (accept) begin
                        valid_q <= 1'b1;
`ifdef PRIO_ENCODER_COUNT_EN
                        count_q <= popcount(in_data);
`endif
                        if (in_data == '0) begin
                            code_q     <= '0;
                            zero_q     <= 1'b1;
                            last_q     <= 1'b1;
                            residual_q <= '0;
                        end else if (!mode) begin
                            code_q     <= in_idx;
                            zero_q     <= 1'b0;
                            last_q     <= 1'b1;
                            residual_q <= '0;
                        end else begin
                            code_q     <= in_idx;
                            zero_q     <= 1'b0;
                            last_q     <= (in_rest == '0);
                            residual_q <= in_rest;
                            if (in_rest != '0) begin
                                state_q <= StBusy;
                            end
                        end
                    end else if (consume) begin
                        valid_q <= 1'b0;
                    end
                end
                StBusy: begin
                    // Advance only when the current beat is taken; otherwise hold everything.
                    if (consume) begin
                        code_q     <= res_idx;
                        last_q     <= (res_rest == '0);
                        residual_q <= res_rest;
                        if (res_rest == '0) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_prio_encoder_stream.sv
module tb_prio_encoder_stream;

    logic       clk;
    logic       rst_n;
    // Shared stimulus for the two 8-bit instances (a: LSB first, b: MSB first).
    logic [7:0] in_data;
    logic       in_valid;
    logic       mode;
    logic       out_ready;
    logic       a_in_ready, a_zero, a_last, a_valid;
    logic [2:0] a_code;
    logic       b_in_ready, b_zero, b_last, b_valid;
    logic [2:0] b_code;
    // 16-bit instance.
    logic [15:0] w_in_data;
    logic        w_in_valid, w_mode, w_out_ready;
    logic        w_in_ready, w_zero, w_last, w_valid;
    logic [3:0]  w_code;
`ifdef PRIO_ENCODER_COUNT_EN
    logic [3:0] a_count;
    logic [3:0] b_count;
    logic [4:0] w_count;
`endif

    int checks;
    int failures;

    prio_encoder_stream #(.WIDTH(8), .CODE_W(3), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_in_ready), .mode(mode), .out_code(a_code), .out_zero(a_zero),
        .out_last(a_last), .out_valid(a_valid), .out_ready(out_ready)
`ifdef PRIO_ENCODER_COUNT_EN
        , .out_count(a_count)
`endif
    );

    prio_encoder_stream #(.WIDTH(8), .CODE_W(3), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .mode(mode), .out_code(b_code), .out_zero(b_zero),
        .out_last(b_last), .out_valid(b_valid), .out_ready(out_ready)
`ifdef PRIO_ENCODER_COUNT_EN
        , .out_count(b_count)
`endif
    );

    prio_encoder_stream #(.WIDTH(16), .CODE_W(4), .MSB_FIRST(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_data(w_in_data), .in_valid(w_in_valid),
        .in_ready(w_in_ready), .mode(w_mode), .out_code(w_code), .out_zero(w_zero),
        .out_last(w_last), .out_valid(w_valid), .out_ready(w_out_ready)
`ifdef PRIO_ENCODER_COUNT_EN
        , .out_count(w_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; samples and drives happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = 1'b0; out_ready = 1'b0;
        w_in_valid = 1'b0; w_in_data = '0; w_mode = 1'b0; w_out_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({a_valid, a_code, a_zero, a_last} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", {a_valid, a_code, a_zero, a_last}, 6'b0);
        end
        checks++;
        if ({a_in_ready, b_in_ready, w_in_ready, w_valid, b_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=%b",
                     {a_in_ready, b_in_ready, w_in_ready, w_valid, b_valid}, 5'b0);
        end
`ifdef PRIO_ENCODER_COUNT_EN
        checks++;
        if (a_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", a_count);
        end
`endif
        rst_n = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b exp=1", a_in_ready);
        end
    endtask

    task automatic test_walking_one();
        mode = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data = 8'd1 << k; in_valid = 1'b1;
            tick();
            checks++;
            if ({a_valid, a_code, a_last, a_zero, a_in_ready} !== {1'b1, 3'(k), 1'b1, 1'b0, 1'b1})
            begin
                failures++;
                $display("FAIL walk_%0d got v=%b code=%0d last=%b zero=%b rdy=%b exp 1 %0d 1 0 1",
                         k, a_valid, a_code, a_last, a_zero, a_in_ready, k);
            end
            checks++;
            if (b_code !== 3'(k)) begin
                failures++;
                $display("FAIL walk_msb_%0d got=%0d exp=%0d", k, b_code, k);
            end
`ifdef PRIO_ENCODER_COUNT_EN
            checks++;
            if (a_count !== 4'd1) begin
                failures++;
                $display("FAIL walk_count_%0d got=%0d exp=1", k, a_count);
            end
`endif
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (a_valid !== 1'b0) begin
            failures++;
            $display("FAIL walk_drain got=%b exp=0", a_valid);
        end
    endtask

    task automatic test_enumerate();
        logic [2:0] exp_a [3];
        logic [2:0] exp_b [3];
        logic       exp_last [3];
        logic       exp_rdy [3];
        exp_a = '{3'd2, 3'd5, 3'd7};
        exp_b = '{3'd7, 3'd5, 3'd2};
        exp_last = '{1'b0, 1'b0, 1'b1};
        exp_rdy = '{1'b0, 1'b0, 1'b1};
        in_data = 8'b1010_0100; mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({a_valid, a_code, a_last, a_in_ready} !== {1'b1, exp_a[i], exp_last[i], exp_rdy[i]})
            begin
                failures++;
                $display("FAIL enum_%0d got v=%b code=%0d last=%b rdy=%b exp 1 %0d %b %b", i,
                         a_valid, a_code, a_last, a_in_ready, exp_a[i], exp_last[i], exp_rdy[i]);
            end
            checks++;
            if ({b_valid, b_code, b_last, b_in_ready} !== {1'b1, exp_b[i], exp_last[i], exp_rdy[i]})
            begin
                failures++;
                $display("FAIL enum_msb_%0d got v=%b code=%0d last=%b rdy=%b exp 1 %0d %b %b", i,
                         b_valid, b_code, b_last, b_in_ready, exp_b[i], exp_last[i], exp_rdy[i]);
            end
`ifdef PRIO_ENCODER_COUNT_EN
            checks++;
            if (a_count !== 4'd3) begin
                failures++;
                $display("FAIL enum_count_%0d got=%0d exp=3", i, a_count);
            end
`endif
            tick();
        end
        checks++;
        if (a_valid !== 1'b0) begin
            failures++;
            $display("FAIL enum_drain got=%b exp=0", a_valid);
        end
    endtask

    task automatic test_backpressure();
        in_data = 8'b1010_0100; mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({a_valid, a_code, a_last, a_zero, a_in_ready} !== {1'b1, 3'd2, 1'b0, 1'b0, 1'b0})
            begin
                failures++;
                $display("FAIL bp_hold_%0d got v=%b code=%0d last=%b zero=%b rdy=%b exp 1 2 0 0 0",
                         i, a_valid, a_code, a_last, a_zero, a_in_ready);
            end
            if (i < 3) tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({a_valid, a_code, a_last} !== {1'b1, 3'd5, 1'b0}) begin
            failures++;
            $display("FAIL bp_code5 got v=%b code=%0d last=%b exp 1 5 0", a_valid, a_code, a_last);
        end
        tick();
        checks++;
        if ({a_valid, a_code, a_last} !== {1'b1, 3'd7, 1'b1}) begin
            failures++;
            $display("FAIL bp_code7 got v=%b code=%0d last=%b exp 1 7 1", a_valid, a_code, a_last);
        end
        tick();
        checks++;
        if (a_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain got=%b exp=0", a_valid);
        end
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        for (int m = 0; m < 2; m++) begin
            in_data = 8'h00; mode = 1'(m); in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            checks++;
            if ({a_valid, a_code, a_zero, a_last} !== {1'b1, 3'd0, 1'b1, 1'b1}) begin
                failures++;
                $display("FAIL zero_mode%0d got v=%b code=%0d zero=%b last=%b exp 1 0 1 1",
                         m, a_valid, a_code, a_zero, a_last);
            end
            checks++;
            if ({b_valid, b_code, b_zero, b_last} !== {1'b1, 3'd0, 1'b1, 1'b1}) begin
                failures++;
                $display("FAIL zero_msb_mode%0d got v=%b code=%0d zero=%b last=%b exp 1 0 1 1",
                         m, b_valid, b_code, b_zero, b_last);
            end
`ifdef PRIO_ENCODER_COUNT_EN
            checks++;
            if (a_count !== 4'd0) begin
                failures++;
                $display("FAIL zero_count_mode%0d got=%0d exp=0", m, a_count);
            end
`endif
            tick();
            checks++;
            if (a_valid !== 1'b0) begin
                failures++;
                $display("FAIL zero_single_beat_mode%0d got=%b exp=0", m, a_valid);
            end
        end
    endtask

    task automatic test_msb_first();
        in_data = 8'b1010_0100; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({b_valid, b_code, b_last, b_zero} !== {1'b1, 3'd7, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL msb_first got v=%b code=%0d last=%b zero=%b exp 1 7 1 0",
                     b_valid, b_code, b_last, b_zero);
        end
        checks++;
        if (a_code !== 3'd2) begin
            failures++;
            $display("FAIL lsb_first got=%0d exp=2", a_code);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        in_data = 8'b1010_0100; mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({a_valid, a_code} !== {1'b1, 3'd2}) begin
            failures++;
            $display("FAIL rstmid_first got v=%b code=%0d exp 1 2", a_valid, a_code);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({a_valid, a_in_ready} !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_abort got v=%b rdy=%b exp 0 0", a_valid, a_in_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_ready got=%b exp=1", a_in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (a_valid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_no_stale_%0d got v=%b code=%0d exp v=0", i, a_valid, a_code);
            end
        end
    endtask

    task automatic test_back_to_back();
        w_in_data = 16'h8001; w_mode = 1'b1; w_in_valid = 1'b1; w_out_ready = 1'b1;
        tick();
        // Offered during BUSY; must only be taken on the final beat.
        w_in_data = 16'h0010; w_mode = 1'b0;
        checks++;
        if ({w_valid, w_code, w_last, w_zero, w_in_ready} !== {1'b1, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL wide_code0 got v=%b code=%0d last=%b zero=%b rdy=%b exp 1 0 0 0 0",
                     w_valid, w_code, w_last, w_zero, w_in_ready);
        end
`ifdef PRIO_ENCODER_COUNT_EN
        checks++;
        if (w_count !== 5'd2) begin
            failures++;
            $display("FAIL wide_count0 got=%0d exp=2", w_count);
        end
`endif
        tick();
        checks++;
        if ({w_valid, w_code, w_last, w_in_ready} !== {1'b1, 4'd15, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL wide_code15 got v=%b code=%0d last=%b rdy=%b exp 1 15 1 1",
                     w_valid, w_code, w_last, w_in_ready);
        end
        tick();
        w_in_valid = 1'b0;
        checks++;
        if ({w_valid, w_code, w_last, w_zero} !== {1'b1, 4'd4, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL wide_b2b_code4 got v=%b code=%0d last=%b zero=%b exp 1 4 1 0",
                     w_valid, w_code, w_last, w_zero);
        end
`ifdef PRIO_ENCODER_COUNT_EN
        checks++;
        if (w_count !== 5'd1) begin
            failures++;
            $display("FAIL wide_count1 got=%0d exp=1", w_count);
        end
`endif
        tick();
        checks++;
        if (w_valid !== 1'b0) begin
            failures++;
            $display("FAIL wide_drain got=%b exp=0", w_valid);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_walking_one();
        test_enumerate();
        test_backpressure();
        test_zero();
        test_msb_first();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prio_encoder_stream.md
Name: prio_encoder_stream

Overview:
- Parametrised successor to the team's 8-to-3 combinational encoder.
- Accepts an N-bit request word over a valid/ready handshake and returns bit indices over a second valid/ready handshake.
- Two modes: priority (one code per word) and enumerate (one code per set bit, serially, with a last flag).
- Sits between request sources (interrupt/arbiter vectors) and consumers that need bit indices.

Parameters:
- WIDTH, 8, input word width; must be >= 2.
- CODE_W, $clog2(WIDTH), code width; default 3 when WIDTH=8.
- MSB_FIRST, 0, 0 = lowest set bit has priority; 1 = highest set bit has priority. Also sets enumeration order.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_data  in  WIDTH  request word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word.
- mode  in  1  0 = priority, 1 = enumerate; sampled only on acceptance.
- out_code  out  CODE_W  bit index.
- out_zero  out  1  accepted word was all zero.
- out_last  out  1  final code for the current word.
- out_valid  out  1  out_code/out_zero/out_last valid.
- out_ready  in  1  consumer takes the current beat.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-low.
  - While rst_n=0 at a rising edge: state=IDLE, residual=0, out_valid=0, out_code=0, out_zero=0, out_last=0.
  - in_ready=0 whenever rst_n=0.
- Transfer definitions:
  - Accept = in_valid & in_ready at a rising edge.
  - Beat consumed = out_valid & out_ready at a rising edge.
- in_ready = (state==IDLE) & (!out_valid | out_ready). Combinational from registers and out_ready; it has no dependence on in_valid.
- FSM states: IDLE, BUSY.
- Accept in IDLE; outputs are registered on that edge, so latency is 1 cycle:
  - in_data==0: out_code=0, out_zero=1, out_last=1, out_valid=1. Stay IDLE.
  - mode=0: out_code = index of priority bit, out_zero=0, out_last=1, out_valid=1. Stay IDLE.
  - mode=1: out_code = index of priority bit, residual = in_data with that bit cleared, out_last = (residual==0), out_valid=1.
    - Next state is BUSY if residual!=0, otherwise IDLE.
- BUSY, on beat consumed:
  - out_code = priority index of residual; clear that bit.
  - out_last = (new residual==0).
  - Go to IDLE when out_last is set.
- BUSY without consumption: all outputs held stable.
- IDLE with beat consumed and no accept: out_valid=0 next cycle.
- IDLE with beat consumed and a simultaneous accept: the new beat replaces the old one with no bubble.
- Throughput: one code per cycle with out_ready held high, in both modes.
- Backpressure: while out_valid=1 and out_ready=0, out_code, out_zero and out_last must not change. in_ready stays 0.
- Priority tie-breaking: only MSB_FIRST decides the order. There is no round-robin.
- mode changes during BUSY are ignored.
- Reset during BUSY aborts the enumeration. The pending beat is dropped and in_ready=1 on the first cycle after rst_n returns high.
- Width rule: out_code is always < WIDTH. Bits of in_data above WIDTH do not exist, so there are no truncation cases.

Optional Feature:
- Macro: PRIO_ENCODER_COUNT_EN.
- Defined:
  - Adds output port out_count, width CODE_W+1.
  - out_count = popcount(in_data), registered on accept.
  - Held constant for every beat of that word. 0 for a zero word. Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Walking one, WIDTH=8, mode=0, out_ready=1: in_data=1<<k for k=0..7 every 10 ns -> out_code=k, out_last=1, out_zero=0, one cycle after each accept.
- Enumerate 8'b1010_0100, mode=1, out_ready=1, MSB_FIRST=0 -> codes 2,5,7 on consecutive cycles; out_last only on 7; in_ready=0 for 2 cycles then 1. With COUNT_EN, out_count=3 on all beats.
- Backpressure: same word with out_ready low for 3 cycles after the first beat -> out_code=2 held stable for 4 cycles, then 5,7; no code lost or duplicated.
- Zero word, either mode -> out_zero=1, out_code=0, out_last=1, single beat; MSB_FIRST=1 with 8'b1010_0100, mode=0 -> out_code=7.
- Reset mid-enumeration: assert rst_n=0 for 1 cycle after code 2 of 8'b1010_0100 -> out_valid=0 next cycle, in_ready=1 after release, codes 5 and 7 never appear.
- WIDTH=16, CODE_W=4, 16'h8001 mode=1 -> codes 0 then 15; back-to-back accept of 16'h0010 mode=0 on the last beat -> code 4 with no idle cycle.
